// File: rtl/ahbs_mem.sv
`timescale 1ns/1ps
// ahbs_mem -- AHB slave backed by a 2^ADDR_W x 32-bit word memory.
// Supports byte, half-word and word transfers and WAIT_STATES (0..3)
// HREADYOUT-low cycles per data phase. Illegal sizes and misaligned
// transfers receive a two-cycle ERROR response.
//
// Ports:
//   I_AHBS_HCLK       bus clock
//   I_AHBS_HRESET_N   asynchronous active-low reset
//   I_AHBS_HSEL       slave select from decoder
//   I_AHBS_HADDR      address-phase address
//   I_AHBS_HTRANS     IDLE=00, BUSY=01, NSEQ=10, SEQ=11
//   I_AHBS_HWRITE     1 = write
//   I_AHBS_HSIZE      000 byte, 001 half, 010 word
//   I_AHBS_HBURST     burst type (not used)
//   I_AHBS_HWDATA     write data, valid in data phase
//   I_AHBS_HREADY     bus-level ready (previous transfer complete)
//   O_AHBS_HREADYOUT  slave ready
//   O_AHBS_HRESP      OKAY=00, ERROR=01
//   O_AHBS_HRDATA     read data
module ahbs_mem #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        I_AHBS_HCLK,
   input  logic        I_AHBS_HRESET_N,
   input  logic        I_AHBS_HSEL,
   input  logic [31:0] I_AHBS_HADDR,
   input  logic [1:0]  I_AHBS_HTRANS,
   input  logic        I_AHBS_HWRITE,
   input  logic [2:0]  I_AHBS_HSIZE,
   input  logic [2:0]  I_AHBS_HBURST,
   input  logic [31:0] I_AHBS_HWDATA,
   input  logic        I_AHBS_HREADY,
   output logic        O_AHBS_HREADYOUT,
   output logic [1:0]  O_AHBS_HRESP,
   output logic [31:0] O_AHBS_HRDATA
);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t            state;
   state_t            state_nxt;

   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        off_q;
   logic [2:0]        size_q;
   logic              write_q;
   logic [1:0]        cnt_q;

   logic [31:0]       mem [2**ADDR_W];

   logic              can_accept;
   logic              accept;
   logic              illegal;
   logic [3:0]        lane_mask;
   logic              unused;

   // Upper address bits, burst type and HTRANS[0] carry no meaning here.
   assign unused = ^{I_AHBS_HBURST, I_AHBS_HADDR[31:ADDR_W+2], I_AHBS_HTRANS[0]};

   // A new address phase can only be taken while this slave is ready.
   assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
   assign accept     = can_accept && I_AHBS_HSEL && I_AHBS_HREADY && I_AHBS_HTRANS[1];

   always_comb begin
      illegal = 1'b0;
      case (I_AHBS_HSIZE)
         3'b000:  illegal = 1'b0;
         3'b001:  illegal = I_AHBS_HADDR[0];
         3'b010:  illegal = |I_AHBS_HADDR[1:0];
         default: illegal = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge I_AHBS_HCLK or negedge I_AHBS_HRESET_N) begin
      if (!I_AHBS_HRESET_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DATA, S_ERR2: begin
            if (!accept) begin
               state_nxt = S_IDLE;
            end else if (illegal) begin
               state_nxt = S_ERR1;
            end else if (WAIT_STATES != 0) begin
               state_nxt = S_WAIT;
            end else begin
               state_nxt = S_DATA;
            end
         end
         S_WAIT: begin
            if (cnt_q == 2'd1) begin
               state_nxt = S_DATA;
            end
         end
         S_ERR1:  state_nxt = S_ERR2;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      O_AHBS_HREADYOUT = 1'b1;
      O_AHBS_HRESP     = 2'b00;
      O_AHBS_HRDATA    = '0;
      case (state)
         S_WAIT: O_AHBS_HREADYOUT = 1'b0;
         S_DATA: begin
            if (!write_q) begin
               O_AHBS_HRDATA = mem[addr_q];
            end
         end
         S_ERR1: begin
            O_AHBS_HREADYOUT = 1'b0;
            O_AHBS_HRESP     = 2'b01;
         end
         S_ERR2:  O_AHBS_HRESP = 2'b01;
         default: ;
      endcase
   end

   // Address-phase capture and wait counter
   always_ff @(posedge I_AHBS_HCLK or negedge I_AHBS_HRESET_N) begin
      if (!I_AHBS_HRESET_N) begin
         addr_q  <= '0;
         off_q   <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         addr_q  <= I_AHBS_HADDR[ADDR_W+1:2];
         off_q   <= I_AHBS_HADDR[1:0];
         size_q  <= I_AHBS_HSIZE;
         write_q <= I_AHBS_HWRITE;
         cnt_q   <= 2'(WAIT_STATES);
      end else if (state == S_WAIT) begin
         cnt_q   <= cnt_q - 2'd1;
      end
   end

   // Only legal transfers reach S_DATA, so size_q/off_q are always aligned here.
   always_comb begin
      case (size_q)
         3'b000:  lane_mask = 4'b0001 << off_q;
         3'b001:  lane_mask = off_q[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   end

   // Write commits on the edge that ends the data phase; an async reset
   // forces S_IDLE first, so a pending write is dropped.
   always_ff @(posedge I_AHBS_HCLK) begin
      if ((state == S_DATA) && write_q) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (lane_mask[i]) begin
               mem[addr_q][8*i +: 8] <= I_AHBS_HWDATA[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ahbs_mem.sv
`timescale 1ns/1ps
// tb_ahbs_mem -- two instances (0 and 2 wait states) driven one after the
// other by a simple AHB master; a scoreboard monitor checks every data phase
// against a word-array reference model.
module tb_ahbs_mem;

   localparam int WS [2] = '{0, 2};
   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   logic        clk;
   logic        rst_n      [2];
   logic        hsel       [2];
   logic [31:0] haddr      [2];
   logic [1:0]  htrans     [2];
   logic        hwrite     [2];
   logic [2:0]  hsize      [2];
   logic [2:0]  hburst     [2];
   logic [31:0] hwdata     [2];
   logic        stall      [2];
   logic        hready_bus [2];
   logic        hreadyout  [2];
   logic [1:0]  hresp      [2];
   logic [31:0] hrdata     [2];

   typedef struct {
      int          dut;
      bit          err;
      bit          rd;
      logic [31:0] data;
      int          cycles;
   } exp_t;

   exp_t        exp_q [$];
   exp_t        cur;
   logic [31:0] ref_mem [2][64];
   bit          in_data [2];
   int          cyc     [2];
   bit          no_mon  [2];
   int          n_cmp;
   int          n_bad;

   assign hready_bus[0] = hreadyout[0] & ~stall[0];
   assign hready_bus[1] = hreadyout[1] & ~stall[1];

   ahbs_mem #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
      .I_AHBS_HCLK(clk), .I_AHBS_HRESET_N(rst_n[0]), .I_AHBS_HSEL(hsel[0]),
      .I_AHBS_HADDR(haddr[0]), .I_AHBS_HTRANS(htrans[0]), .I_AHBS_HWRITE(hwrite[0]),
      .I_AHBS_HSIZE(hsize[0]), .I_AHBS_HBURST(hburst[0]), .I_AHBS_HWDATA(hwdata[0]),
      .I_AHBS_HREADY(hready_bus[0]), .O_AHBS_HREADYOUT(hreadyout[0]),
      .O_AHBS_HRESP(hresp[0]), .O_AHBS_HRDATA(hrdata[0])
   );

   ahbs_mem #(.ADDR_W(10), .WAIT_STATES(2)) dut1 (
      .I_AHBS_HCLK(clk), .I_AHBS_HRESET_N(rst_n[1]), .I_AHBS_HSEL(hsel[1]),
      .I_AHBS_HADDR(haddr[1]), .I_AHBS_HTRANS(htrans[1]), .I_AHBS_HWRITE(hwrite[1]),
      .I_AHBS_HSIZE(hsize[1]), .I_AHBS_HBURST(hburst[1]), .I_AHBS_HWDATA(hwdata[1]),
      .I_AHBS_HREADY(hready_bus[1]), .O_AHBS_HREADYOUT(hreadyout[1]),
      .O_AHBS_HRESP(hresp[1]), .O_AHBS_HRDATA(hrdata[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: record the transfer outcome and update the word array.
   task automatic model_push(input int d, input logic [31:0] addr, input logic wr,
                             input logic [2:0] size, input logic [31:0] wdata);
      exp_t e;
      int   w;
      int   off;
      int   nbytes;
      w      = int'(addr[11:2]);
      off    = int'(addr[1:0]);
      e.dut  = d;
      e.err  = (size > 3'd2) || (size == 3'd1 && off % 2 != 0) || (size == 3'd2 && off != 0);
      e.rd   = !wr;
      e.data = '0;
      e.cycles = e.err ? 2 : WS[d] + 1;
      if (!e.err) begin
         nbytes = 1 << size;
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (b >= off && b < off + nbytes) ref_mem[d][w][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            e.data = ref_mem[d][w];
         end
      end
      exp_q.push_back(e);
   endtask

   // Present one address phase and hold it until the bus accepts it.
   task automatic issue(input int d, input logic sel, input logic [1:0] trans,
                        input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata);
      int budget;
      hsel[d] = sel; htrans[d] = trans; haddr[d] = addr; hwrite[d] = wr; hsize[d] = size;
      budget = 0;
      @(negedge clk);
      while (!hready_bus[d] && budget < 20) begin
         budget++;
         @(negedge clk);
      end
      n_cmp++;
      if (!hready_bus[d]) begin
         n_bad++;
         $display("FAIL addr_timeout: dut%0d hready=%0b required 1 within 20 cycles", d, hready_bus[d]);
      end
      @(posedge clk); #1;
      hwdata[d] = wdata;
      if (sel && trans[1]) model_push(d, addr, wr, size, wdata);
   endtask

   task automatic idle(input int d, input int n);
      hsel[d] = 1'b0; htrans[d] = T_IDLE;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n[d] || no_mon[d]) begin
            in_data[d] = 1'b0;
         end else begin
            if (in_data[d]) begin
               cyc[d]++;
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL sb_empty: dut%0d data phase got none expected 1", d);
                  in_data[d] = 1'b0;
               end else begin
                  cur = exp_q[0];
                  chk($sformatf("dut%0d_hresp", d), 32'(hresp[d]), cur.err ? 32'd1 : 32'd0);
                  if (hreadyout[d]) begin
                     void'(exp_q.pop_front());
                     chk($sformatf("dut%0d_owner", d), 32'(d), 32'(cur.dut));
                     chk($sformatf("dut%0d_cycles", d), 32'(cyc[d]), 32'(cur.cycles));
                     chk($sformatf("dut%0d_hrdata", d), hrdata[d], (cur.rd && !cur.err) ? cur.data : '0);
                     in_data[d] = 1'b0;
                  end else begin
                     chk($sformatf("dut%0d_hrdata_stall", d), hrdata[d], '0);
                     if (cyc[d] > 8) begin
                        n_cmp++; n_bad++;
                        $display("FAIL stall_overrun: dut%0d stalled %0d cycles expected %0d", d, cyc[d], cur.cycles);
                        void'(exp_q.pop_front());
                        in_data[d] = 1'b0;
                     end
                  end
               end
            end else begin
               chk($sformatf("dut%0d_idle_ready", d), 32'(hreadyout[d]), 32'd1);
               chk($sformatf("dut%0d_idle_resp", d), 32'(hresp[d]), 32'd0);
               chk($sformatf("dut%0d_idle_rdata", d), hrdata[d], '0);
            end
            if (hsel[d] && htrans[d][1] && hready_bus[d]) begin
               in_data[d] = 1'b1;
               cyc[d]     = 0;
            end
         end
      end
   end

   task automatic run_dut(input int d);
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  tr;
      int          r;

      for (int w = 0; w < 64; w++) issue(d, 1'b1, T_NSEQ, 32'(w * 4), 1'b1, 3'b010, $urandom);

      // Write then immediately read the same word
      issue(d, 1'b1, T_NSEQ, 32'h10, 1'b1, 3'b010, 32'hDEADBEEF);
      issue(d, 1'b1, T_NSEQ, 32'h10, 1'b0, 3'b010, 32'h0);

      // Byte and half-word lanes
      issue(d, 1'b1, T_NSEQ, 32'h20, 1'b1, 3'b010, 32'h11223344);
      issue(d, 1'b1, T_NSEQ, 32'h21, 1'b1, 3'b000, 32'h0000AA00);
      issue(d, 1'b1, T_NSEQ, 32'h20, 1'b0, 3'b010, 32'h0);
      issue(d, 1'b1, T_NSEQ, 32'h22, 1'b1, 3'b001, 32'h55660000);
      issue(d, 1'b1, T_NSEQ, 32'h20, 1'b0, 3'b010, 32'h0);

      // Misaligned word and oversize transfers give ERROR, memory untouched
      issue(d, 1'b1, T_NSEQ, 32'h00, 1'b1, 3'b010, 32'h0BADF00D);
      issue(d, 1'b1, T_NSEQ, 32'h02, 1'b1, 3'b010, 32'hFFFFFFFF);
      issue(d, 1'b1, T_NSEQ, 32'h00, 1'b1, 3'b011, 32'hFFFFFFFF);
      issue(d, 1'b1, T_NSEQ, 32'h00, 1'b0, 3'b010, 32'h0);

      // INCR4 read burst
      for (int i = 0; i < 4; i++) issue(d, 1'b1, T_NSEQ, 32'h40 + 32'(4 * i), 1'b1, 3'b010, 32'(i + 1));
      idle(d, 6);
      hburst[d] = 3'b011;
      for (int i = 0; i < 4; i++) issue(d, 1'b1, i == 0 ? T_NSEQ : T_SEQ, 32'h40 + 32'(4 * i), 1'b0, 3'b010, 32'h0);

      // BUSY and IDLE with HSEL between beats: no transfer, no write
      issue(d, 1'b1, T_NSEQ, 32'h40, 1'b0, 3'b010, 32'h0);
      issue(d, 1'b1, T_BUSY, 32'h44, 1'b1, 3'b010, 32'h0);
      issue(d, 1'b1, T_IDLE, 32'h44, 1'b1, 3'b010, 32'hA5A5A5A5);
      issue(d, 1'b1, T_SEQ,  32'h44, 1'b0, 3'b010, 32'h5A5A5A5A);
      hburst[d] = 3'b000;

      // HREADY low from another slave: address phase must be ignored
      idle(d, 6);
      stall[d] = 1'b1;
      hsel[d] = 1'b1; htrans[d] = T_NSEQ; haddr[d] = 32'h48; hwrite[d] = 1'b1; hsize[d] = 3'b010;
      repeat (3) @(posedge clk);
      #1;
      hwdata[d] = 32'h12345678;
      htrans[d] = T_IDLE; hsel[d] = 1'b0; stall[d] = 1'b0;
      idle(d, 4);
      issue(d, 1'b1, T_NSEQ, 32'h48, 1'b0, 3'b010, 32'h0);

      // Randomised traffic over words 0..63 with random upper address bits
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 99);
         tr = (r < 10) ? T_IDLE : (r < 18) ? T_BUSY : (r < 55) ? T_NSEQ : T_SEQ;
         r = $urandom_range(0, 9);
         sz = (r < 3) ? 3'b000 : (r < 6) ? 3'b001 : (r < 9) ? 3'b010 : 3'($urandom_range(3, 7));
         a = $urandom;
         a[11:2] = 10'($urandom_range(0, 63));
         hburst[d] = 3'($urandom_range(0, 7));
         issue(d, $urandom_range(0, 9) != 0, tr, a, 1'($urandom_range(0, 1)), sz, $urandom);
      end
      idle(d, 8);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = T_IDLE; hwrite[d] = 1'b0;
         hsize[d] = 3'b010; hburst[d] = '0; hwdata[d] = '0; stall[d] = 1'b0;
         in_data[d] = 1'b0; cyc[d] = 0; no_mon[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("dut%0d_reset_ready", d), 32'(hreadyout[d]), 32'd1);
         chk($sformatf("dut%0d_reset_resp", d), 32'(hresp[d]), 32'd0);
         chk($sformatf("dut%0d_reset_rdata", d), hrdata[d], '0);
      end
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;

      run_dut(0);
      run_dut(1);

      // Reset in the middle of a write's wait states on the 2-wait instance
      no_mon[1] = 1'b1;
      hsel[1] = 1'b1; htrans[1] = T_NSEQ; haddr[1] = 32'h30; hwrite[1] = 1'b1; hsize[1] = 3'b010;
      @(negedge clk);
      @(posedge clk); #1;
      hwdata[1] = 32'hCAFEF00D; htrans[1] = T_IDLE; hsel[1] = 1'b0;
      @(negedge clk);
      chk("rst_mid_wait_ready_low", 32'(hreadyout[1]), 32'd0);
      #2 rst_n[1] = 1'b0;
      #1;
      chk("rst_async_ready", 32'(hreadyout[1]), 32'd1);
      chk("rst_async_resp", 32'(hresp[1]), 32'd0);
      chk("rst_async_rdata", hrdata[1], '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n[1] = 1'b1;
      no_mon[1] = 1'b0;
      issue(1, 1'b1, T_NSEQ, 32'h30, 1'b0, 3'b010, 32'h0);
      idle(1, 8);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      n_bad++;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
